// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Pixel generator sitting just upstream of the VGA timing controller.
//   For every pixel clock it turns the background-local coordinate into one
//   read address per sprite ROM. It then merges the eight RGB332 texels that
//   come back by fixed priority with colour-key transparency. The result is
//   expanded to RGB888 and registered.
//
//   Pipeline (one pixel per clock, no stalls):
//     stage A  : address generation, enable captured      (1 cycle)
//     ROM      : external synchronous sprite ROMs         (ROM_LATENCY cycles)
//     stage C  : priority merge + RGB888 expansion, RGB register
//   From the edge that samples X/Y/SPRITES_EN to RGB: ROM_LATENCY + 1 edges,
//   i.e. RGB appears ROM_LATENCY + 2 cycles after the inputs are presented.
//
// Ports
//   VGA_CLK     in   1    pixel clock
//   RESET       in   1    synchronous, active-high; clears the whole pipeline
//   X, Y        in   10   background-local coordinate (10'h3FF off-screen)
//   SPRITES_EN  in   8    {BG, BLUE, GREEN, RED, YELLOW, LOSE, WIN, PWR}
//   ROM_ADDR    out  136  slice i*17 +: 17 addresses the ROM of enable bit i
//   ROM_DATA    in   64   slice i*8 +: 8 is the RGB332 texel of enable bit i
//   RGB         out  24   {R, G, B} to the controller
module sprite_compositor #(
  parameter int         ROM_LATENCY = 1,
  parameter logic [7:0] KEY_COLOR   = 8'hE3,
  parameter int         BG_HS       = 360,
  parameter int         BTN_HS      = 168,
  parameter int         BLUE_X      = 191,
  parameter int         BLUE_Y      = 191,
  parameter int         GREEN_X     = 1,
  parameter int         GREEN_Y     = 1,
  parameter int         RED_X       = 191,
  parameter int         RED_Y       = 1,
  parameter int         YELLOW_X    = 1,
  parameter int         YELLOW_Y    = 191,
  parameter int         LOSE_X      = 0,
  parameter int         LOSE_Y      = 110,
  parameter int         LOSE_HS     = 360,
  parameter int         WIN_X       = 0,
  parameter int         WIN_Y       = 120,
  parameter int         WIN_HS      = 360,
  parameter int         PWR_X       = 170,
  parameter int         PWR_Y       = 198,
  parameter int         PWR_HS      = 20
) (
  input  logic         VGA_CLK,
  input  logic         RESET,
  input  logic [9:0]   X,
  input  logic [9:0]   Y,
  input  logic [7:0]   SPRITES_EN,
  output logic [135:0] ROM_ADDR,
  input  logic [63:0]  ROM_DATA,
  output logic [23:0]  RGB
);

  // Sprite geometry indexed by enable bit: 7 = BG, 6 = BLUE ... 0 = PWR.
  function automatic logic [10:0] org_x(input int i);
    case (i)
      6:       org_x = 11'(BLUE_X);
      5:       org_x = 11'(GREEN_X);
      4:       org_x = 11'(RED_X);
      3:       org_x = 11'(YELLOW_X);
      2:       org_x = 11'(LOSE_X);
      1:       org_x = 11'(WIN_X);
      0:       org_x = 11'(PWR_X);
      default: org_x = 11'd0;
    endcase
  endfunction

  function automatic logic [10:0] org_y(input int i);
    case (i)
      6:       org_y = 11'(BLUE_Y);
      5:       org_y = 11'(GREEN_Y);
      4:       org_y = 11'(RED_Y);
      3:       org_y = 11'(YELLOW_Y);
      2:       org_y = 11'(LOSE_Y);
      1:       org_y = 11'(WIN_Y);
      0:       org_y = 11'(PWR_Y);
      default: org_y = 11'd0;
    endcase
  endfunction

  function automatic logic [16:0] stride(input int i);
    case (i)
      7:       stride = 17'(BG_HS);
      2:       stride = 17'(LOSE_HS);
      1:       stride = 17'(WIN_HS);
      0:       stride = 17'(PWR_HS);
      default: stride = 17'(BTN_HS);
    endcase
  endfunction

  // (Y - Yi) * stride + (X - Xi), modulo 2^17. Offsets are signed 11-bit and
  // sign-extended so a coordinate left of / above the origin wraps exactly
  // like the two's-complement result; no clamping is done.
  function automatic logic [16:0] sprite_addr(input int i,
                                              input logic [9:0] x,
                                              input logic [9:0] y);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [16:0]        dx_w;
    logic [16:0]        dy_w;
    dx   = $signed({1'b0, x}) - $signed(org_x(i));
    dy   = $signed({1'b0, y}) - $signed(org_y(i));
    dx_w = {{6{dx[10]}}, dx};
    dy_w = {{6{dy[10]}}, dy};
    return dy_w * stride(i) + dx_w;
  endfunction

  // RGB332 -> RGB888 by bit replication so full-scale maps to 8'hFF.
  function automatic logic [23:0] rgb332_to_888(input logic [7:0] t);
    return {t[7:5], t[7:5], t[7:6],
            t[4:2], t[4:2], t[4:3],
            t[1:0], t[1:0], t[1:0], t[1:0]};
  endfunction

  logic [135:0] addr_d;
  logic [135:0] addr_q;
  logic [7:0]   en_p0_q;
  logic [7:0]   en_pd_q [ROM_LATENCY];
  logic [7:0]   en_al;
  logic [7:0]   pix;
  logic [23:0]  rgb_d;
  logic [23:0]  rgb_q;

  // ---- stage A: address generation ----
  always_comb begin
    addr_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (SPRITES_EN[i]) addr_d[i*17 +: 17] = sprite_addr(i, X, Y);
    end
  end

  // ---- ROM latency: enable delay line, aligned with ROM_DATA ----
  assign en_al = en_pd_q[ROM_LATENCY-1];

  // ---- stage C: priority merge ----
  // BG is the fallback and ignores the key colour; walking the overlays from
  // BLUE (bit 6) down to PWR (bit 0) lets the higher-priority one win.
  always_comb begin
    pix = ROM_DATA[63:56];
    for (int i = 6; i >= 0; i--) begin
      if (en_al[i] && (ROM_DATA[i*8 +: 8] != KEY_COLOR)) pix = ROM_DATA[i*8 +: 8];
    end
    rgb_d = en_al[7] ? rgb332_to_888(pix) : 24'h000000;
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      addr_q  <= '0;
      en_p0_q <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) en_pd_q[k] <= '0;
      rgb_q   <= '0;
    end else begin
      addr_q     <= addr_d;
      en_p0_q    <= SPRITES_EN;
      en_pd_q[0] <= en_p0_q;
      for (int k = 1; k < ROM_LATENCY; k++) en_pd_q[k] <= en_pd_q[k-1];
      rgb_q      <= rgb_d;
    end
  end

  assign ROM_ADDR = addr_q;
  assign RGB      = rgb_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed vectors, a reference model of the
// compositing rules kept as sample history, and a few literal expectations.
module tb_sprite_compositor;

  localparam int L     = 1;
  localparam int DEPTH = 4096;

  logic         VGA_CLK = 1'b0;
  logic         RESET;
  logic [9:0]   X;
  logic [9:0]   Y;
  logic [7:0]   SPRITES_EN;
  logic [135:0] ROM_ADDR;
  logic [63:0]  ROM_DATA;
  logic [23:0]  RGB;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         sx   [DEPTH];
  int         sy   [DEPTH];
  logic [7:0] sen  [DEPTH];
  logic       srst [DEPTH];

  logic [63:0] rom_pipe [L];

  sprite_compositor #(.ROM_LATENCY(L)) dut (
    .VGA_CLK    (VGA_CLK),
    .RESET      (RESET),
    .X          (X),
    .Y          (Y),
    .SPRITES_EN (SPRITES_EN),
    .ROM_ADDR   (ROM_ADDR),
    .ROM_DATA   (ROM_DATA),
    .RGB        (RGB)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // ROM contents: address LSBs scrambled per sprite, with a few planted texels.
  function automatic logic [7:0] tex(input int s, input int a);
    logic [7:0] lo;
    lo = a[7:0];
    case (s)
      7: return (a == 725) ? 8'hFF : lo;
      0: begin
        if (a == 210) return 8'h1C;
        if (a == 211) return 8'hE3;
        return lo ^ 8'h5A;
      end
      3: begin
        if (a == 1711) return 8'h03;
        if (a == 1712) return 8'hE3;
        return lo ^ 8'h33;
      end
      default: return lo ^ 8'(s * 17);
    endcase
  endfunction

  function automatic int addr_of(input int s, input int x, input int y);
    int ox, oy, st;
    case (s)
      7: begin ox = 0;   oy = 0;   st = 360; end
      6: begin ox = 191; oy = 191; st = 168; end
      5: begin ox = 1;   oy = 1;   st = 168; end
      4: begin ox = 191; oy = 1;   st = 168; end
      3: begin ox = 1;   oy = 191; st = 168; end
      2: begin ox = 0;   oy = 110; st = 360; end
      1: begin ox = 0;   oy = 120; st = 360; end
      default: begin ox = 170; oy = 198; st = 20; end
    endcase
    return ((y - oy) * st + (x - ox)) & 32'h1FFFF;
  endfunction

  function automatic logic [135:0] exp_addr(input int x, input int y, input logic [7:0] en);
    logic [135:0] v;
    v = '0;
    for (int s = 0; s < 8; s++)
      if (en[s]) v[s*17 +: 17] = 17'(addr_of(s, x, y));
    return v;
  endfunction

  function automatic logic [23:0] expand(input logic [7:0] t);
    logic [2:0] r, g;
    logic [1:0] b;
    r = t[7:5]; g = t[4:2]; b = t[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  // What the controller must see for one sampled pixel.
  function automatic logic [23:0] exp_pix(input int x, input int y, input logic [7:0] en);
    logic [7:0] t;
    if (!en[7]) return 24'h000000;
    for (int s = 0; s < 7; s++) begin  // PWR first, BLUE last
      if (en[s]) begin
        t = tex(s, addr_of(s, x, y));
        if (t != 8'hE3) return expand(t);
      end
    end
    return expand(tex(7, addr_of(7, x, y)));
  endfunction

  function automatic logic [63:0] rom_read(input logic [135:0] a);
    logic [63:0] r;
    for (int s = 0; s < 8; s++) r[s*8 +: 8] = tex(s, int'(a[s*17 +: 17]));
    return r;
  endfunction

  // Synchronous ROM with L cycles of read latency.
  always @(posedge VGA_CLK) begin
    rom_pipe[0] <= rom_read(ROM_ADDR);
    for (int k = 1; k < L; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign ROM_DATA = rom_pipe[L-1];

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Record what the DUT samples on every edge.
  initial begin : sampler
    forever begin
      @(posedge VGA_CLK);
      cyc++;
      if (cyc < DEPTH) begin
        srst[cyc] = RESET;
        sx[cyc]   = int'(X);
        sy[cyc]   = int'(Y);
        sen[cyc]  = SPRITES_EN;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin : compare
    logic [135:0] ea;
    logic [23:0]  er;
    bit           z;
    int           src;
    forever begin
      @(negedge VGA_CLK);
      if (cyc >= 1 && cyc < DEPTH) begin
        ea = srst[cyc] ? '0 : exp_addr(sx[cyc], sy[cyc], sen[cyc]);
        chk("model_rom_addr", ROM_ADDR, ea);
        if (cyc >= L + 2) begin
          src = cyc - L - 1;
          z   = 1'b0;
          for (int k = src; k <= cyc; k++) if (srst[k]) z = 1'b1;
          er  = z ? 24'h000000 : exp_pix(sx[src], sy[src], sen[src]);
          chk("model_rgb", {112'd0, RGB}, {112'd0, er});
        end
      end
    end
  end

  task automatic vec(input logic [9:0] x, input logic [9:0] y, input logic [7:0] en,
                     input logic [23:0] exp_rgb, input string nm);
    X = x; Y = y; SPRITES_EN = en;
    repeat (L + 2) @(negedge VGA_CLK);
    chk(nm, {112'd0, RGB}, {112'd0, exp_rgb});
  endtask

  initial begin : stim
    RESET = 1'b1;
    // Reset held three cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      X = 10'($urandom); Y = 10'($urandom); SPRITES_EN = 8'($urandom);
      @(negedge VGA_CLK);
      chk("reset_rgb", {112'd0, RGB}, 136'd0);
      chk("reset_addr", ROM_ADDR, 136'd0);
    end

    // Release with background-only pixel (5,2): address 725, texel FF.
    RESET = 1'b0; X = 10'd5; Y = 10'd2; SPRITES_EN = 8'h80;
    @(negedge VGA_CLK);
    chk("bg_addr", {119'd0, ROM_ADDR[7*17 +: 17]}, 136'd725);
    repeat (L) @(negedge VGA_CLK);
    chk("bg_rgb_early", {112'd0, RGB}, 136'd0);
    @(negedge VGA_CLK);
    chk("bg_rgb", {112'd0, RGB}, {112'd0, 24'hFFFFFF});

    // PWR over BG: address 210, texel 1C.
    X = 10'd180; Y = 10'd208; SPRITES_EN = 8'h81;
    @(negedge VGA_CLK);
    chk("pwr_addr", {119'd0, ROM_ADDR[0 +: 17]}, 136'd210);
    repeat (L + 1) @(negedge VGA_CLK);
    chk("pwr_opaque", {112'd0, RGB}, {112'd0, 24'h00FF00});
    // PWR keyed at 211 -> BG texel 0x35 at address 75061.
    vec(10'd181, 10'd208, 8'h81, 24'h24B655, "pwr_keyed");

    // BLUE + YELLOW overlap.
    vec(10'd200, 10'd200, 8'hC8, 24'h0000FF, "yellow_over_blue");
    vec(10'd201, 10'd200, 8'hC8, 24'h92B600, "blue_under_keyed_yellow");

    // Off-screen with everything disabled.
    vec(10'h3FF, 10'h3FF, 8'h00, 24'h000000, "offscreen");

    // Streaming sweep, with a mid-line reset.
    for (int x = 0; x < 360; x++) begin
      RESET = (x == 100 || x == 101);
      X = 10'(x); Y = 10'd0; SPRITES_EN = 8'h80;
      @(negedge VGA_CLK);
    end
    RESET = 1'b0;

    // Enables toggling pixel by pixel, including BG dropping out.
    for (int x = 160; x < 240; x++) begin
      X = 10'(x); Y = 10'd200;
      SPRITES_EN = (x % 7 == 0) ? 8'((x * 37) % 128) : (8'h80 | 8'((x * 37) % 128));
      @(negedge VGA_CLK);
    end

    vec(10'h3FF, 10'h3FF, 8'h00, 24'h000000, "final_offscreen");
    repeat (2) @(negedge VGA_CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
